// File: rtl/mtm_alu_frame_decoder.sv
// ALU frame decoder: turns deserializer packets into ALU requests.
// Collects 8 data bytes (B then A, MSB first) and one command packet
// {1'b0, OP, CRC}, checks count/CRC/opcode and pulses frame_valid or
// err_valid one cycle after the command strobe.
// Ports: clk, rst (async, active-low), packet[9:0], data_valid,
//        A, B, op, frame_valid, err_valid, err_flags {data,crc,op}.
// Optional: define FRAME_TIMEOUT_EN to drop stale partial frames.
module mtm_alu_frame_decoder #(
    parameter int DATA_PACKETS   = 8,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  packet,
    input  logic        data_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  op,
    output logic        frame_valid,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    localparam int CW = $clog2(DATA_PACKETS + 2);
    localparam logic [CW-1:0] FULL = CW'(DATA_PACKETS);
    localparam logic [CW-1:0] OVF  = CW'(DATA_PACKETS + 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] REPORT  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          rep_err_q, rep_err_d;
    logic [2:0]    flags_q, flags_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   buf_q, buf_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [2:0]    op_q, op_d;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Payload MSB of the command and the stop bit carry no information.
    logic unused_bits;
    assign unused_bits = ^{packet[8], packet[0]};

    logic       is_data, is_cmd, op_ok, cnt_ok, crc_ok;
    logic [2:0] cmd_op;
    logic [3:0] cmd_crc, crc_calc;
    logic [2:0] err;

    // CRC-4, poly x^4+x+1, MSB first, init 0, no final xor.
    function automatic logic [3:0] crc4(input logic [67:0] m);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ m[i];
            c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
        end
        return c;
    endfunction

    assign is_data  = data_valid & ~packet[9];
    assign is_cmd   = data_valid & packet[9];
    assign cmd_op   = packet[7:5];
    assign cmd_crc  = packet[4:1];
    assign crc_calc = crc4({buf_q, 1'b1, cmd_op});
    assign cnt_ok   = (cnt_q == FULL);
    assign crc_ok   = (crc_calc == cmd_crc);

    always_comb begin
        case (cmd_op)
            3'b000, 3'b001, 3'b100, 3'b101: op_ok = 1'b1;
            default:                        op_ok = 1'b0;
        endcase
    end

    // Priority: count, then CRC, then opcode; exactly one flag set.
    assign err[2] = ~cnt_ok;
    assign err[1] = cnt_ok & ~crc_ok;
    assign err[0] = cnt_ok & crc_ok & ~op_ok;

    always_comb begin
        state_d   = COLLECT;
        rep_err_d = 1'b0;
        flags_d   = 3'b000;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
`ifdef FRAME_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        if (is_cmd) begin
            state_d   = REPORT;
            cnt_d     = '0;
            buf_d     = '0;
            rep_err_d = |err;
            flags_d   = err;
            if (err == 3'b000) begin
                b_d  = buf_q[63:32];
                a_d  = buf_q[31:0];
                op_d = cmd_op;
            end
        end else if (is_data) begin
            // Extras beyond a full frame are dropped; count parks at OVF.
            if (cnt_q < FULL) begin
                buf_d = {buf_q[55:0], packet[8:1]};
            end
            if (cnt_q != OVF) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
`ifdef FRAME_TIMEOUT_EN
        if (data_valid || cnt_q == '0) begin
            tmo_d = '0;
        end else if (tmo_q == TLAST) begin
            tmo_d = '0;
            cnt_d = '0;
            buf_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            rep_err_q <= 1'b0;
            flags_q   <= 3'b000;
            cnt_q     <= '0;
            buf_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
`ifdef FRAME_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rep_err_q <= rep_err_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
`ifdef FRAME_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign op          = op_q;
    assign frame_valid = (state_q == REPORT) & ~rep_err_q;
    assign err_valid   = (state_q == REPORT) & rep_err_q;
    assign err_flags   = flags_q;

endmodule
